// File: rtl/fetch_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter_pkg
// Shared pipeline package for the memory arbiter and the stages around it.
// Holds the arbiter state encoding, the default wait-state count and the
// word-alignment mask that IF_Stage and the memory stage also use.
// ---------------------------------------------------------------------------
package fetch_mem_arbiter_pkg;

  // Arbiter states: idle, an access in progress for data or fetch, and the
  // single acknowledge cycle that follows each access.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC_D = 3'd1,
    ACC_I = 3'd2,
    ACK_D = 3'd3,
    ACK_I = 3'd4
  } arb_state_t;

  // Default number of memory cycles each access is held for.
  localparam int unsigned ARB_LATENCY_DEFAULT = 3;

  // Clears the two byte-offset bits of a byte address.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter
// Shares one single-ported unified memory between the fetch stage and the
// memory stage. Each access holds the memory for LATENCY cycles, then a
// one-cycle acknowledge goes back to the requester. Data side wins ties.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   if_req/if_addr      fetch read request and byte address
//   if_flush            branch taken: kills pending or in-flight fetch
//   if_ack/if_rdata     fetch acknowledge pulse and registered instruction
//   d_rd_req/d_wr_req   data load / store requests (both high = store)
//   d_addr/d_wdata      data byte address and store data
//   d_ack/d_rdata       data acknowledge pulse and registered load data
//   m_en/m_we           memory access active / write strobe
//   m_addr/m_wdata      word-aligned memory address and write data
//   m_rdata             combinational read data from the memory
//   busy                high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module fetch_mem_arbiter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = ARB_LATENCY_DEFAULT,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  // Alignment mask widened to ADDR_W: invert the offset bits of the shared
  // 32-bit mask, resize, and invert back so upper bits stay set.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(~WORD_ALIGN_MASK);

  // The wait-state counter counts down to zero, so it starts at LATENCY-1.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  arb_state_t        r_state;
  logic [3:0]        r_cnt;
  logic              r_kill;
  logic              r_isStore;
  logic              r_ifAck;
  logic              r_dAck;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_mEn;
  logic              r_mWe;
  logic [ADDR_W-1:0] r_mAddr;
  logic [DATA_W-1:0] r_mWdata;

  logic              w_dReq;
  logic              w_ifGrantable;
  logic              w_cntDone;
  logic              w_fetchKilled;

  // Request qualification and end-of-access detection. A flush arriving on
  // the very edge a fetch completes still counts as killing that fetch.
  assign w_dReq        = d_rd_req | d_wr_req;
  assign w_ifGrantable = if_req & ~if_flush;
  assign w_cntDone     = (r_cnt == 4'd0);
  assign w_fetchKilled = r_kill | if_flush;

  // Single FSM block: arbitration in IDLE latches address, data and op so
  // requester inputs no longer matter; the ACC states hold the memory for
  // LATENCY cycles; the ACK states pulse the acknowledge and never grant,
  // so a requester that drops its request after the ack is served once.
  // The write strobe is raised one edge early so it is high only in the
  // final access cycle, giving exactly one write per store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_kill    <= 1'b0;
      r_isStore <= 1'b0;
      r_ifAck   <= 1'b0;
      r_dAck    <= 1'b0;
      r_ifRdata <= '0;
      r_dRdata  <= '0;
      r_mEn     <= 1'b0;
      r_mWe     <= 1'b0;
      r_mAddr   <= '0;
      r_mWdata  <= '0;
    end else begin
      r_ifAck <= 1'b0;
      r_dAck  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (w_dReq) begin
            r_state   <= ACC_D;
            r_cnt     <= CNT_LOAD;
            r_isStore <= d_wr_req;
            r_mEn     <= 1'b1;
            r_mWe     <= d_wr_req && (CNT_LOAD == 4'd0);
            r_mAddr   <= d_addr & ALIGN_MASK;
            r_mWdata  <= d_wdata;
          end else if (w_ifGrantable) begin
            r_state   <= ACC_I;
            r_cnt     <= CNT_LOAD;
            r_isStore <= 1'b0;
            r_mEn     <= 1'b1;
            r_mWe     <= 1'b0;
            r_mAddr   <= if_addr & ALIGN_MASK;
          end
        end

        ACC_D: begin
          if (w_cntDone) begin
            r_state <= ACK_D;
            r_mEn   <= 1'b0;
            r_mWe   <= 1'b0;
            r_dAck  <= 1'b1;
            if (!r_isStore) begin
              r_dRdata <= m_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_isStore && (r_cnt == 4'd1)) begin
              r_mWe <= 1'b1;
            end
          end
        end

        ACC_I: begin
          if (w_cntDone) begin
            r_state <= ACK_I;
            r_mEn   <= 1'b0;
            r_kill  <= w_fetchKilled;
            if (!w_fetchKilled) begin
              r_ifRdata <= m_rdata;
              r_ifAck   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (if_flush) begin
              r_kill <= 1'b1;
            end
          end
        end

        ACK_D, ACK_I: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Everything leaving the block comes straight from registered state.
  assign if_ack   = r_ifAck;
  assign if_rdata = r_ifRdata;
  assign d_ack    = r_dAck;
  assign d_rdata  = r_dRdata;
  assign m_en     = r_mEn;
  assign m_we     = r_mWe;
  assign m_addr   = r_mAddr;
  assign m_wdata  = r_mWdata;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fetch_mem_arbiter
// Self-checking bench for fetch_mem_arbiter with LATENCY=3. Cycle 0 is the
// cycle in which a request is first presented; outputs are sampled on the
// falling edge of each cycle. Expected read data is queued when a request
// is driven and popped when the matching acknowledge appears.
// ---------------------------------------------------------------------------
module tb_fetch_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_rd_req;
  logic        d_wr_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  int          testsRun  = 0;
  int          failCount = 0;

  logic [31:0] ifQ[$];
  logic [31:0] dQ[$];
  logic [31:0] expI;
  logic [31:0] expD;
  logic [31:0] monExp;

  int          writeCount = 0;
  logic [31:0] lastWAddr  = 32'h0;
  logic [31:0] lastWData  = 32'h0;

  fetch_mem_arbiter #(
    .LATENCY(3),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_flush(if_flush),
    .if_ack  (if_ack),
    .if_rdata(if_rdata),
    .d_rd_req(d_rd_req),
    .d_wr_req(d_wr_req),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one fixed instruction word at 0x8, otherwise a pattern
  // derived from the word address so every location reads back distinctly.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h8) ? 32'hE3A0_0014 : (a ^ 32'h5A5A_0000);
  endfunction

  always_comb m_rdata = memWord(m_addr);

  // Memory write log: a write happens on a rising edge with m_en & m_we.
  always @(posedge clk) begin
    if (m_en === 1'b1 && m_we === 1'b1) begin
      writeCount = writeCount + 1;
      lastWAddr  = m_addr;
      lastWData  = m_wdata;
    end
  end

  // Scoreboard monitor: every acknowledge must match a queued expectation.
  always @(negedge clk) begin
    if (if_ack === 1'b1) begin
      testsRun++;
      if (ifQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL if_ack_spurious got ack with if_rdata=%h, required no ack", if_rdata);
      end else begin
        monExp = ifQ.pop_front();
        if (if_rdata !== monExp) begin
          failCount++;
          $display("[TB] FAIL if_rdata_sb got %h, required %h", if_rdata, monExp);
        end
      end
    end
    if (d_ack === 1'b1) begin
      testsRun++;
      if (dQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL d_ack_spurious got ack with d_rdata=%h, required no ack", d_rdata);
      end else begin
        monExp = dQ.pop_front();
        if (d_rdata !== monExp) begin
          failCount++;
          $display("[TB] FAIL d_rdata_sb got %h, required %h", d_rdata, monExp);
        end
      end
    end
  end

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive all requester inputs in one go.
  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifA,
                               input logic flush, input logic dRd,
                               input logic dWr, input logic [31:0] dA,
                               input logic [31:0] dW);
    if_req   = ifReq;
    if_addr  = ifA;
    if_flush = flush;
    d_rd_req = dRd;
    d_wr_req = dWr;
    d_addr   = dA;
    d_wdata  = dW;
  endtask

  // Reset state of every output while rst is held.
  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expI = 32'h0;
    expD = 32'h0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({if_ack, d_ack, m_en, m_we, busy} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl got %b, required 00000", {if_ack, d_ack, m_en, m_we, busy});
    end
    testsRun++;
    if ({if_rdata, d_rdata, m_addr, m_wdata} !== 128'h0) begin
      failCount++;
      $display("[TB] FAIL reset_data got %h %h %h %h, required all zero", if_rdata, d_rdata, m_addr, m_wdata);
    end
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  // Single fetch: m_en in cycles 1-3, if_ack in cycle 4, idle in cycle 5.
  task automatic test_fetch_only();
    nextCycle();
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expI = memWord(32'h8);
    ifQ.push_back(expI);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      testsRun++;
      if (m_en !== (c >= 1 && c <= 3) || busy !== (c >= 1 && c <= 4) || if_ack !== (c == 4)) begin
        failCount++;
        $display("[TB] FAIL fetch_timing c%0d got en/busy/ack=%b%b%b, required %b%b%b", c, m_en, busy, if_ack,
                 (c >= 1 && c <= 3), (c >= 1 && c <= 4), (c == 4));
      end
      if (c >= 1 && c <= 3) begin
        testsRun++;
        if (m_addr !== 32'h8 || m_we !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL fetch_addr c%0d got addr=%h we=%b, required 00000008 0", c, m_addr, m_we);
        end
      end
      if (c == 4) begin
        testsRun++;
        if (if_rdata !== 32'hE3A0_0014) begin
          failCount++;
          $display("[TB] FAIL fetch_rdata got %h, required e3a00014", if_rdata);
        end
      end
      nextCycle();
      if (c == 4) if_req = 1'b0;
    end
  endtask

  // Fetch and load together: load wins (ack cycle 4), fetch acks cycle 9.
  task automatic test_simultaneous();
    nextCycle();
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
    expD = memWord(32'h400);
    dQ.push_back(expD);
    expI = memWord(32'h8);
    ifQ.push_back(expI);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      testsRun++;
      if (d_ack !== (c == 4) || if_ack !== (c == 9)) begin
        failCount++;
        $display("[TB] FAIL simul_ack c%0d got d/if=%b%b, required %b%b", c, d_ack, if_ack, (c == 4), (c == 9));
      end
      if ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) begin
        testsRun++;
        if (m_en !== 1'b1 || m_addr !== ((c <= 3) ? 32'h400 : 32'h8)) begin
          failCount++;
          $display("[TB] FAIL simul_addr c%0d got en=%b addr=%h, required 1 %h", c, m_en, m_addr,
                   ((c <= 3) ? 32'h400 : 32'h8));
        end
      end
      nextCycle();
      if (c == 4) d_rd_req = 1'b0;
      if (c == 9) if_req = 1'b0;
    end
  endtask

  // Store to an unaligned address: aligned m_addr, one write in cycle 3.
  task automatic test_store();
    int wc;
    wc = writeCount;
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40B, 32'h2000);
    dQ.push_back(expD);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      testsRun++;
      if (m_we !== (c == 3) || d_ack !== (c == 4) || m_en !== (c >= 1 && c <= 3)) begin
        failCount++;
        $display("[TB] FAIL store_timing c%0d got we/ack/en=%b%b%b, required %b%b%b", c, m_we, d_ack, m_en,
                 (c == 3), (c == 4), (c >= 1 && c <= 3));
      end
      if (c >= 1 && c <= 3) begin
        testsRun++;
        if (m_addr !== 32'h408 || m_wdata !== 32'h2000) begin
          failCount++;
          $display("[TB] FAIL store_addr c%0d got %h/%h, required 00000408/00002000", c, m_addr, m_wdata);
        end
      end
      nextCycle();
      if (c == 4) d_wr_req = 1'b0;
    end
    testsRun++;
    if (writeCount - wc !== 1 || lastWAddr !== 32'h408 || lastWData !== 32'h2000) begin
      failCount++;
      $display("[TB] FAIL store_write got n=%0d %h/%h, required 1 00000408/00002000", writeCount - wc,
               lastWAddr, lastWData);
    end
  endtask

  // Flush pulsed in cycle 2: access completes, no ack, if_rdata unchanged.
  task automatic test_flush_inflight();
    nextCycle();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      testsRun++;
      if (m_en !== (c >= 1 && c <= 3) || busy !== (c >= 1 && c <= 4) || if_ack !== 1'b0 || if_rdata !== expI) begin
        failCount++;
        $display("[TB] FAIL flush_fly c%0d got en/busy/ack=%b%b%b rdata=%h, required %b%b0 %h", c, m_en, busy,
                 if_ack, if_rdata, (c >= 1 && c <= 3), (c >= 1 && c <= 4), expI);
      end
      nextCycle();
      if (c == 1) begin
        if_flush = 1'b1;
        if_req   = 1'b0;
      end
      if (c == 2) if_flush = 1'b0;
    end
  endtask

  // Flush together with a fetch request in IDLE: no grant that cycle.
  task automatic test_flush_idle();
    nextCycle();
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    testsRun++;
    if (m_en !== 1'b0 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL flush_idle got en=%b busy=%b, required 0 0", m_en, busy);
    end
    nextCycle();
  endtask

  // Reset in cycle 2 of a store: outputs drop at once, nothing is written,
  // and a following load is served normally.
  task automatic test_reset_mid_store();
    int wc;
    wc = writeCount;
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h500, 32'hDEAD_BEEF);
    dQ.push_back(expD);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    dQ.delete();
    ifQ.delete();
    expD = 32'h0;
    expI = 32'h0;
    #1;
    testsRun++;
    if (m_en !== 1'b0 || m_we !== 1'b0 || busy !== 1'b0 || d_rdata !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL rst_mid got en/we/busy=%b%b%b d_rdata=%h, required 000 0", m_en, m_we, busy, d_rdata);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) nextCycle();
    rst = 1'b0;
    nextCycle();
    testsRun++;
    if (writeCount !== wc) begin
      failCount++;
      $display("[TB] FAIL rst_nowrite got %0d writes, required 0", writeCount - wc);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
    expD = memWord(32'h600);
    dQ.push_back(expD);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      testsRun++;
      if (d_ack !== (c == 4) || m_en !== (c >= 1 && c <= 3)) begin
        failCount++;
        $display("[TB] FAIL rst_after c%0d got ack/en=%b%b, required %b%b", c, d_ack, m_en, (c == 4),
                 (c >= 1 && c <= 3));
      end
      nextCycle();
      if (c == 4) d_rd_req = 1'b0;
    end
  endtask

  // Both data requests: behaves as a store, d_rdata left unchanged.
  task automatic test_dual_d();
    int wc;
    wc = writeCount;
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h700, 32'h1234);
    dQ.push_back(expD);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      testsRun++;
      if (m_we !== (c == 3) || d_ack !== (c == 4)) begin
        failCount++;
        $display("[TB] FAIL dual_timing c%0d got we/ack=%b%b, required %b%b", c, m_we, d_ack, (c == 3), (c == 4));
      end
      nextCycle();
      if (c == 4) begin
        d_rd_req = 1'b0;
        d_wr_req = 1'b0;
      end
    end
    testsRun++;
    if (writeCount - wc !== 1 || lastWAddr !== 32'h700 || lastWData !== 32'h1234) begin
      failCount++;
      $display("[TB] FAIL dual_write got n=%0d %h/%h, required 1 00000700/00001234", writeCount - wc,
               lastWAddr, lastWData);
    end
  endtask

  // Load request held across two transactions: one per LATENCY+2 cycles.
  task automatic test_back_to_back();
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    expD = memWord(32'h100);
    dQ.push_back(expD);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      testsRun++;
      if (d_ack !== (c == 4 || c == 9) || m_en !== ((c >= 1 && c <= 3) || (c >= 6 && c <= 8))) begin
        failCount++;
        $display("[TB] FAIL b2b c%0d got ack/en=%b%b, required %b%b", c, d_ack, m_en, (c == 4 || c == 9),
                 ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)));
      end
      nextCycle();
      if (c == 4) begin
        d_addr = 32'h104;
        expD   = memWord(32'h104);
        dQ.push_back(expD);
      end
      if (c == 9) d_rd_req = 1'b0;
    end
  endtask

  // Run every scenario, confirm no expected acknowledge is still pending,
  // then print the summary.
  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_store();
    test_flush_inflight();
    test_flush_idle();
    test_reset_mid_store();
    test_dual_d();
    test_back_to_back();
    repeat (3) nextCycle();
    testsRun++;
    if (ifQ.size() != 0 || dQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL sb_drain got %0d/%0d pending acks, required 0/0", ifQ.size(), dQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
